// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding an 8N1 UART serialiser.
// Bytes arrive on a valid/ready handshake, are buffered in a power-of-two
// FIFO and shifted out LSB first with one start and one stop bit.
module uart_tx_fifo #(
  parameter int TX_FIFO_DEPTH = 4,
  parameter int CLKS_PER_BIT  = 434
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_data_in,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  output logic [TX_FIFO_DEPTH:0]   o_tx_free,
  output logic                     o_tx,
  output logic                     o_busy
);

  localparam int DATA_W  = 8;
  localparam int ENTRIES = 1 << TX_FIFO_DEPTH;
  localparam int PTR_W   = TX_FIFO_DEPTH + 1;
  localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(ENTRIES);
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_W-1:0] mem [ENTRIES];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, count;
  logic              full, empty, push, pop;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_last;

  // The extra pointer MSB separates the full case from the empty case.
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  // Ready depends only on registered occupancy, never on i_wr_valid.
  assign o_wr_ready = !full;
  assign push       = i_wr_valid && o_wr_ready;
  assign o_tx_free  = FULL_CNT - count;
  assign o_busy     = (state_q != IDLE) || !empty;
  assign o_tx       = tx_q;
  assign baud_last  = (baud_q == BAUD_MAX);

  // FIFO storage: data only, left unreset since pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[TX_FIFO_DEPTH-1:0]] <= i_data_in;
  end

  // FIFO pointers; push and pop on the same edge leave the count unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Serialiser control state: FSM state, baud counter and bit index.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  // Shift register holds the byte being sent; contents are don't-care in IDLE.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
  end

  // Line register follows the current state, so the pin lags the FSM by one
  // cycle uniformly and every bit still lasts CLKS_PER_BIT cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tx_q <= 1'b1;
    else       tx_q <= tx_d;
  end

  // Line level for the current state.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Next-state logic; STOP pops straight into START when more bytes wait.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr[TX_FIFO_DEPTH-1:0]];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr[TX_FIFO_DEPTH-1:0]];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes push expected bytes into a queue,
// a UART receiver process decodes o_tx frames and checks them against it.
module tb_uart_tx_fifo;

  localparam int  D    = 4;
  localparam int  CPB  = 4;
  localparam int  ENT  = 16;
  localparam time TCLK = 10;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [7:0]   i_data_in = 8'h00;
  logic         i_wr_valid = 1'b0;
  logic         o_wr_ready;
  logic [D:0]   o_tx_free;
  logic         o_tx;
  logic         o_busy;

  uart_tx_fifo #(.TX_FIFO_DEPTH(D), .CLKS_PER_BIT(CPB)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data_in  (i_data_in),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .o_tx_free  (o_tx_free),
    .o_tx       (o_tx),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         frames_started = 0;
  int         frames_done = 0;
  time        last_fall = 0;
  int         rst_epoch = 0;
  bit         inv_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Receiver: samples each bit mid-period; a reset during a frame aborts it.
  initial begin : monitor
    int         ep;
    logic [9:0] bits;
    bit         ab;
    forever begin
      @(negedge o_tx);
      if (i_rst !== 1'b0) continue;
      ep = rst_epoch;
      frames_started++;
      last_fall = $time;
      ab = 1'b0;
      bits = '0;
      repeat (3) @(negedge i_clk);
      for (int b = 0; b < 10; b++) begin
        if (b > 0) repeat (CPB) @(negedge i_clk);
        if (rst_epoch != ep) begin
          ab = 1'b1;
          break;
        end
        bits[b] = o_tx;
      end
      if (!ab) begin
        frames_done++;
        check("start_bit", int'(bits[0]), 0);
        check("stop_bit", int'(bits[9]), 1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got byte %0d, expected no frame", bits[8:1]);
        end else begin
          check("rx_byte", int'(bits[8:1]), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // Occupancy invariants during the wrap-around burst test.
  always @(negedge i_clk) begin
    if (inv_en) begin
      check("inv_ready", int'(o_wr_ready), int'(o_tx_free != 0));
      check("inv_free_range", int'(o_tx_free <= ENT), 1);
      if (o_tx_free != ENT) check("inv_busy", int'(o_busy), 1);
    end
  end

  initial begin : watchdog
    #(TCLK * 60000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] b, output time t_acc);
    int guard = 0;
    @(negedge i_clk);
    i_data_in  = b;
    i_wr_valid = 1'b1;
    while (!o_wr_ready && guard < 2000) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_wr_ready) begin
      tests++;
      fails++;
      $display("FAIL wr_timeout: got ready=0, expected ready=1");
    end else begin
      exp_q.push_back(b);
    end
    @(posedge i_clk);
    t_acc = $time;
    #1 i_wr_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int lim);
    int g = 0;
    while (frames_started < n && g < lim) begin
      @(negedge i_clk);
      g++;
    end
    check("frame_wait", int'(frames_started >= n), 1);
  endtask

  task automatic wait_idle(input int lim);
    int g = 0;
    while ((o_busy || exp_q.size() != 0) && g < lim) begin
      @(negedge i_clk);
      g++;
    end
    check("drain", int'(!o_busy && exp_q.size() == 0), 1);
    repeat (4) @(negedge i_clk);
  endtask

  initial begin : stimulus
    time ta, tb, t1, t2, tf, tdummy;
    int  f0, f1, acc, g;

    // Reset values, while held and after 20 idle cycles
    repeat (3) @(negedge i_clk);
    check("rst_tx", int'(o_tx), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ready", int'(o_wr_ready), 1);
    check("rst_free", int'(o_tx_free), ENT);
    i_rst = 1'b0;
    repeat (20) @(negedge i_clk);
    check("idle_tx", int'(o_tx), 1);
    check("idle_busy", int'(o_busy), 0);
    check("idle_ready", int'(o_wr_ready), 1);
    check("idle_free", int'(o_tx_free), ENT);

    // Single byte 0x55: latency two edges, busy clears 41 edges after accept
    f0 = frames_started;
    write_byte(8'h55, ta);
    check("busy_after_write", int'(o_busy), 1);
    wait_frames(f0 + 1, 20);
    check("latency_edges", int'((last_fall - ta) / TCLK), 2);
    g = 0;
    while (o_busy && g < 100) begin
      @(posedge i_clk);
      #1;
      g++;
    end
    tb = $time - 1;
    check("busy_drop_edges", int'((tb - ta) / TCLK), 41);
    wait_idle(1000);

    // Hold valid 20 cycles: 17 accepted (one popped), the rest dropped
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      i_data_in  = 8'(k);
      i_wr_valid = 1'b1;
      if (o_wr_ready) begin
        exp_q.push_back(8'(k));
        acc++;
      end
    end
    @(negedge i_clk);
    check("full_ready", int'(o_wr_ready), 0);
    check("full_free", int'(o_tx_free), 0);
    check("full_busy", int'(o_busy), 1);
    i_wr_valid = 1'b0;
    check("accepted_count", acc, 17);
    wait_idle(20000);

    // Back-to-back frames: start of frame 2 exactly one frame after frame 1
    f0 = frames_started;
    write_byte(8'hA3, ta);
    write_byte(8'h0F, tdummy);
    wait_frames(f0 + 1, 20);
    t1 = last_fall;
    wait_frames(f0 + 2, 100);
    t2 = last_fall;
    check("frame_spacing", int'((t2 - t1) / TCLK), 10 * CPB);
    wait_idle(1000);

    // Reset during DATA bit 3 of 0xF0 with 5 more bytes queued
    f0 = frames_started;
    write_byte(8'hF0, ta);
    for (int k = 1; k <= 5; k++) write_byte(8'(k), tdummy);
    wait_frames(f0 + 1, 20);
    tf = last_fall;
    while ($time < tf + 18 * TCLK) @(negedge i_clk);
    check("pre_reset_bit3", int'(o_tx), 0);
    check("pre_reset_free", int'(o_tx_free), ENT - 5);
    rst_epoch++;
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_tx", int'(o_tx), 1);
    check("async_rst_free", int'(o_tx_free), ENT);
    check("async_rst_ready", int'(o_wr_ready), 1);
    check("async_rst_busy", int'(o_busy), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    f1 = frames_started;
    repeat (200) @(negedge i_clk);
    check("no_frames_after_reset", frames_started, f1);
    check("post_reset_tx", int'(o_tx), 1);
    check("post_reset_busy", int'(o_busy), 0);

    // 40 bytes in bursts of 8 around pops: pointer wrap past 2x depth
    inv_en = 1'b1;
    for (int bu = 0; bu < 5; bu++) begin
      for (int j = 0; j < 8; j++) write_byte(8'(((bu * 8 + j) * 37 + 11) & 255), tdummy);
      repeat (60) @(negedge i_clk);
    end
    wait_idle(20000);
    inv_en = 1'b0;
    check("wrap_free_end", int'(o_tx_free), ENT);
    check("wrap_tx_end", int'(o_tx), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
